// File: rtl/lmem_pkg.sv
// Shared types, constants and helpers for the banked local scratchpad.
package lmem_pkg;

   localparam int          LMEM_WORD_W          = 32;
   localparam logic [31:0] LMEM_MMIO_CYCLE_ADDR = 32'h0;
   localparam int          LMEM_MAX_BANKS       = 16;
   localparam int          LMEM_MAX_LINE_W      = LMEM_WORD_W * LMEM_MAX_BANKS;

   // Sized for the largest supported bank count; narrower instances zero the top.
   typedef struct packed {
      logic                        we;
      logic                        is_vector;
      logic [31:0]                 addr;
      logic [4*LMEM_MAX_BANKS-1:0] be;
      logic [LMEM_MAX_LINE_W-1:0]  wdata;
   } lmem_req_t;

   function automatic logic [LMEM_MAX_BANKS-1:0] bank_mask(input logic [31:0] addr,
                                                           input logic        is_vector,
                                                           input int          num_banks);
      logic [LMEM_MAX_BANKS-1:0] m;
      int                        b;
      b = int'(addr[31:2]) & (num_banks - 1);
      for (int i = 0; i < LMEM_MAX_BANKS; i++) begin
         m[i] = (i < num_banks) && (is_vector || (b == i));
      end
      return m;
   endfunction

endpackage

// File: rtl/lmem_bank.sv
// One byte-enabled single-port 32-bit bank with synchronous read (maps to one BRAM).
module lmem_bank
   import lmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int INDEX_W     = $clog2(DEPTH_WORDS)
) (
   input  logic                   clk,
   input  logic                   en_i,
   input  logic                   we_i,
   input  logic [3:0]             be_i,
   input  logic [INDEX_W-1:0]     idx_i,
   input  logic [LMEM_WORD_W-1:0] wdata_i,
   output logic [LMEM_WORD_W-1:0] rdata_o
);

   logic [LMEM_WORD_W-1:0] mem_q [DEPTH_WORDS];
   logic [LMEM_WORD_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            for (int k = 0; k < 4; k++) begin
               if (be_i[k]) begin
                  mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[idx_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/lmem_banked_mp.sv
// Banked multi-port scratchpad: round-robin bank-conflict arbiter, 1-cycle read response.
// Optional cycle-counter MMIO word at address 0 when LMEM_MMIO_CYCLE_EN is defined.
module lmem_banked_mp
   import lmem_pkg::*;
#(
   parameter int NUM_BANKS   = 4,
   parameter int DEPTH_WORDS = 1024,
   parameter int NUM_PORTS   = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_PORTS-1:0]              req_valid,
   output logic [NUM_PORTS-1:0]              req_ready,
   input  logic [NUM_PORTS-1:0]              req_we,
   input  logic [NUM_PORTS-1:0]              req_is_vector,
   input  logic [NUM_PORTS*32-1:0]           req_addr,
   input  logic [NUM_PORTS*32*NUM_BANKS-1:0] req_wdata,
   input  logic [NUM_PORTS*4*NUM_BANKS-1:0]  req_be,
   output logic [NUM_PORTS-1:0]              resp_valid,
   output logic [NUM_PORTS*32*NUM_BANKS-1:0] resp_rdata
);

   localparam int BANK_W  = $clog2(NUM_BANKS);
   localparam int INDEX_W = $clog2(DEPTH_WORDS);
   localparam int LINE_W  = LMEM_WORD_W * NUM_BANKS;
   localparam int PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   lmem_req_t                 req       [NUM_PORTS];
   logic [LMEM_MAX_BANKS-1:0] mask_full [NUM_PORTS];
   logic [NUM_BANKS-1:0]      mask      [NUM_PORTS];
   logic [NUM_PORTS-1:0]      grant;
   logic                      any_denied;
   logic [PTR_W-1:0]          rr_q, rr_d;
   logic                      unused_x;

   logic                      bank_en  [NUM_BANKS];
   logic                      bank_we  [NUM_BANKS];
   logic [3:0]                bank_be  [NUM_BANKS];
   logic [INDEX_W-1:0]        bank_idx [NUM_BANKS];
   logic [LMEM_WORD_W-1:0]    bank_wd  [NUM_BANKS];
   logic [LMEM_WORD_W-1:0]    bank_rd  [NUM_BANKS];

   logic [NUM_PORTS-1:0]      rd_q, rd_d;
   logic [NUM_PORTS-1:0]      rd_vec_q;
   logic [BANK_W-1:0]         rd_bank_q [NUM_PORTS];
   logic [LINE_W-1:0]         fresh     [NUM_PORTS];
   logic [LINE_W-1:0]         hold_q    [NUM_PORTS];

   always_comb begin
      unused_x = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         req[p]                          = '0;
         req[p].we                       = req_we[p];
         req[p].is_vector                = req_is_vector[p];
         req[p].addr                     = req_addr[32*p +: 32];
         req[p].be[4*NUM_BANKS-1:0]      = req_be[4*NUM_BANKS*p +: 4*NUM_BANKS];
         req[p].wdata[LINE_W-1:0]        = req_wdata[LINE_W*p +: LINE_W];
         mask_full[p]                    = bank_mask(req[p].addr, req[p].is_vector, NUM_BANKS);
         mask[p]                         = mask_full[p][NUM_BANKS-1:0];
         unused_x                        = unused_x ^ (^req[p]) ^ (^mask_full[p]);
      end
   end

   // Round-robin visit from rr_q; a port wins if its banks are still free this cycle.
   always_comb begin
      logic [NUM_BANKS-1:0] used;
      int                   p;
      grant      = '0;
      used       = '0;
      any_denied = 1'b0;
      p          = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         p = (int'(rr_q) + k) % NUM_PORTS;
         if (req_valid[p] && !rst) begin
            if ((mask[p] & used) == '0) begin
               grant[p] = 1'b1;
               used     = used | mask[p];
            end else begin
               any_denied = 1'b1;
            end
         end
      end
   end

   assign req_ready = grant;
   assign rd_d      = grant & ~req_we;

   always_comb begin
      rr_d = rr_q;
      if (any_denied) begin
         rr_d = (rr_q == PTR_W'(NUM_PORTS - 1)) ? '0 : rr_q + PTR_W'(1);
      end
   end

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_en[b]  = 1'b0;
         bank_we[b]  = 1'b0;
         bank_be[b]  = '0;
         bank_idx[b] = '0;
         bank_wd[b]  = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p] && mask[p][b]) begin
               bank_en[b]  = 1'b1;
               bank_we[b]  = req[p].we;
               bank_idx[b] = req[p].addr[2+BANK_W +: INDEX_W];
               if (req[p].is_vector) begin
                  bank_be[b] = req[p].be[4*b +: 4];
                  bank_wd[b] = req[p].wdata[32*b +: 32];
               end else begin
                  bank_be[b] = req[p].be[3:0];
                  bank_wd[b] = req[p].wdata[31:0];
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      lmem_bank #(
         .DEPTH_WORDS (DEPTH_WORDS),
         .INDEX_W     (INDEX_W)
      ) u_bank (
         .clk     (clk),
         .en_i    (bank_en[g]),
         .we_i    (bank_we[g]),
         .be_i    (bank_be[g]),
         .idx_i   (bank_idx[g]),
         .wdata_i (bank_wd[g]),
         .rdata_o (bank_rd[g])
      );
   end

   // Grant edge -> response cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q <= '0;
         rd_q <= '0;
      end else begin
         rr_q <= rr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         rd_vec_q[p]  <= req_is_vector[p];
         rd_bank_q[p] <= req[p].addr[2 +: BANK_W];
      end
   end

`ifdef LMEM_MMIO_CYCLE_EN
   logic [31:0]          cnt_q;
   logic [NUM_PORTS-1:0] mmio_q;
   logic [31:0]          snap_q [NUM_PORTS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 32'd1;
      end else begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         mmio_q[p] <= (req[p].addr[31:2] == LMEM_MMIO_CYCLE_ADDR[31:2]);
         snap_q[p] <= cnt_q;
      end
   end
`endif

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         fresh[p] = '0;
         if (rd_vec_q[p]) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
               fresh[p][32*b +: 32] = bank_rd[b];
            end
         end else begin
            fresh[p][31:0] = bank_rd[rd_bank_q[p]];
         end
`ifdef LMEM_MMIO_CYCLE_EN
         if (mmio_q[p]) begin
            fresh[p]       = '0;
            fresh[p][31:0] = snap_q[p];
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            hold_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (rd_q[p]) begin
               hold_q[p] <= fresh[p];
            end
         end
      end
   end

   assign resp_valid = rd_q;

   always_comb begin
      resp_rdata = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         resp_rdata[LINE_W*p +: LINE_W] = rd_q[p] ? fresh[p] : hold_q[p];
      end
   end

endmodule

// File: tb/tb_lmem_banked_mp.sv
// Bench for lmem_banked_mp: directed cases with literal expectations plus a randomized run
// compared every cycle against a word-array reference model.
`timescale 1ns/1ps
module tb_lmem_banked_mp;

   localparam int NB = 4;
   localparam int DW = 1024;
   localparam int NP = 2;
   localparam int LW = 32 * NB;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     req_valid, req_ready, req_we, req_is_vector, resp_valid;
   logic [NP*32-1:0]  req_addr;
   logic [NP*LW-1:0]  req_wdata, resp_rdata;
   logic [NP*4*NB-1:0] req_be;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lmem_banked_mp #(
      .NUM_BANKS   (NB),
      .DEPTH_WORDS (DW),
      .NUM_PORTS   (NP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_is_vector (req_is_vector),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_be        (req_be),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata)
   );

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0]   mem_m  [NB][DW];
   logic [LW-1:0] hold_m [NP];
   logic [LW-1:0] pend_d [NP];
   logic [NP-1:0] pend_v;
   int            rr_m;
   logic [31:0]   cnt_m;
   bit            was_rst;

   always @(negedge clk) begin
      logic [NB-1:0] used, m;
      logic [NP-1:0] g;
      logic [LW-1:0] line, expd;
      logic [31:0]   a;
      int            p, bk, ix, src;
      bit            denied;
      if (rst) begin
         cnt_m   = 32'd1;
         was_rst = 1'b1;
         rr_m    = 0;
         pend_v  = '0;
         for (int q = 0; q < NP; q++) hold_m[q] = '0;
      end else if (was_rst) begin
         was_rst = 1'b0;
      end else begin
         cnt_m = cnt_m + 32'd1;
      end

      for (int q = 0; q < NP; q++) begin
         expd = pend_v[q] ? pend_d[q] : hold_m[q];
         chk($sformatf("model_rvalid%0d", q), resp_valid[q], pend_v[q]);
         chk($sformatf("model_rdata%0d", q), resp_rdata[q*LW +: LW], expd);
         if (pend_v[q]) hold_m[q] = pend_d[q];
      end

      g = '0; used = '0; denied = 1'b0;
      if (!rst) begin
         for (int k = 0; k < NP; k++) begin
            p  = (rr_m + k) % NP;
            a  = req_addr[32*p +: 32];
            bk = int'((a >> 2) % NB);
            ix = int'((a >> 4) % DW);
            if (req_is_vector[p]) m = '1;
            else begin m = '0; m[bk] = 1'b1; end
            if (req_valid[p]) begin
               if ((m & used) == '0) begin
                  g[p] = 1'b1;
                  used = used | m;
                  if (req_we[p]) begin
                     for (int b = 0; b < NB; b++) begin
                        if (req_is_vector[p] || b == bk) begin
                           src = req_is_vector[p] ? b : 0;
                           for (int k2 = 0; k2 < 4; k2++) begin
                              if (req_be[p*4*NB + 4*src + k2])
                                 mem_m[b][ix][8*k2 +: 8] = req_wdata[p*LW + 32*src + 8*k2 +: 8];
                           end
                        end
                     end
                  end else begin
                     line = '0;
                     if (req_is_vector[p]) begin
                        for (int b = 0; b < NB; b++) line[32*b +: 32] = mem_m[b][ix];
                     end else begin
                        line[31:0] = mem_m[bk][ix];
                     end
`ifdef LMEM_MMIO_CYCLE_EN
                     if ((a >> 2) == 0) begin
                        line       = '0;
                        line[31:0] = cnt_m;
                     end
`endif
                     pend_d[p] = line;
                  end
               end else begin
                  denied = 1'b1;
               end
            end
         end
      end
      for (int q = 0; q < NP; q++) chk($sformatf("model_ready%0d", q), req_ready[q], g[q]);
      pend_v = g & ~req_we;
      if (denied) rr_m = (rr_m + 1) % NP;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = '0; req_we = '0; req_is_vector = '0;
      req_addr = '0; req_wdata = '0; req_be = '0;
   endtask

   task automatic set_req(input int p, input logic we, input logic vec, input logic [31:0] addr,
                          input logic [LW-1:0] wd, input logic [4*NB-1:0] be);
      req_valid[p]          = 1'b1;
      req_we[p]             = we;
      req_is_vector[p]      = vec;
      req_addr[32*p +: 32]  = addr;
      req_wdata[LW*p +: LW] = wd;
      req_be[4*NB*p +: 4*NB] = be;
   endtask

   task automatic new_rand(input int p);
      logic [31:0]   a;
      logic [LW-1:0] wd;
      if ($urandom_range(0, 3) == 0) begin
         req_valid[p] = 1'b0;
      end else begin
         a        = $urandom;
         a[13:4]  = 10'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) a[31:14] = '0;
         if ($urandom_range(0, 7) == 0) a[31:2] = '0;
         for (int b = 0; b < NB; b++) wd[32*b +: 32] = $urandom;
         set_req(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a, wd,
                 16'($urandom));
      end
   endtask

   initial begin
      logic [NP-1:0]  rdy;
      logic [LW-1:0]  line;
      logic [31:0]    c0, c1, exp0, expd;
      rst = 1'b0;
      idle();
      #1 rst = 1'b1;
      set_req(0, 1'b0, 1'b0, 32'h10, '0, '0);
      @(negedge clk);
      chk("rst_ready", LW'(req_ready), '0);
      chk("rst_rvalid", LW'(resp_valid), '0);
      chk("rst_rdata0", resp_rdata[LW-1:0], '0);
      step();
      rst = 1'b0;
      idle();

      for (int i = 0; i < 40; i++) begin
         for (int b = 0; b < NB; b++) line[32*b +: 32] = 32'hA000_0000 | 32'(i << 8) | 32'(b);
         set_req(0, 1'b1, 1'b1, 32'(i * 16), line, '1);
         step();
      end
      idle();

      set_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 16'hF);
      @(negedge clk); chk("t1_wr_ready", LW'(req_ready[0]), 1);
      step();
      set_req(0, 1'b0, 1'b0, 32'h10, '0, '0);
      @(negedge clk); chk("t1_rd_ready", LW'(req_ready[0]), 1);
      step(); idle();
      @(negedge clk);
      chk("t1_rvalid", LW'(resp_valid[0]), 1);
      chk("t1_rdata", resp_rdata[LW-1:0], 128'hDEADBEEF);

      step();
      set_req(0, 1'b0, 1'b0, 32'h104, '0, '0);
      set_req(1, 1'b0, 1'b0, 32'h108, '0, '0);
      @(negedge clk); chk("t2_ready", LW'(req_ready), 2'b11);
      step(); idle();
      @(negedge clk);
      chk("t2_rvalid", LW'(resp_valid), 2'b11);
      chk("t2_rdata0", resp_rdata[LW-1:0], 128'hA0001001);
      chk("t2_rdata1", resp_rdata[2*LW-1:LW], 128'hA0001002);

      step();
      set_req(0, 1'b0, 1'b0, 32'h104, '0, '0);
      set_req(1, 1'b0, 1'b0, 32'h114, '0, '0);
      @(negedge clk); chk("t3_ready_c1", LW'(req_ready), 2'b01);
      step();
      @(negedge clk); chk("t3_ready_c2", LW'(req_ready), 2'b10);
      step();
      @(negedge clk); chk("t3_ready_c3", LW'(req_ready), 2'b01);
      step(); idle();

      set_req(0, 1'b1, 1'b1, 32'h200, 128'h33333333_22222222_11111111_00000000, 16'h0F0F);
      @(negedge clk); chk("t4_wr_ready", LW'(req_ready[0]), 1);
      step();
      set_req(0, 1'b0, 1'b1, 32'h200, '0, '0);
      step(); idle();
      @(negedge clk);
      chk("t4_rvalid", LW'(resp_valid[0]), 1);
      chk("t4_line", resp_rdata[LW-1:0], 128'hA0002003_22222222_A0002001_00000000);

      step();
      set_req(0, 1'b0, 1'b1, 32'h200, '0, '0);
      set_req(1, 1'b0, 1'b0, 32'h10, '0, '0);
      @(negedge clk); chk("t5_ready_c1", LW'(req_ready), 2'b10);
      step();
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("t5_ready_c2", LW'(req_ready), 2'b01);
      chk("t5_rvalid_c2", LW'(resp_valid), 2'b10);
      chk("t5_rdata1", resp_rdata[2*LW-1:LW], 128'hDEADBEEF);
      step(); idle();
      @(negedge clk);
      chk("t5_rvalid_c3", LW'(resp_valid), 2'b01);
      chk("t5_line0", resp_rdata[LW-1:0], 128'hA0002003_22222222_A0002001_00000000);

      step();
      set_req(0, 1'b0, 1'b0, 32'h10, '0, '0);
      step();
      rst = 1'b1;
      idle();
      @(negedge clk); chk("rstmid_rvalid", LW'(resp_valid), '0);
      step();
      rst = 1'b0;
      set_req(0, 1'b0, 1'b0, 32'h0, '0, '0);
      @(negedge clk); chk("rstmid_rdata", resp_rdata[LW-1:0], '0);
      step(); idle();
`ifdef LMEM_MMIO_CYCLE_EN
      exp0 = 32'd1;
      expd = 32'd5;
`else
      exp0 = 32'hA0000000;
      expd = 32'd0;
`endif
      @(negedge clk);
      c0 = resp_rdata[31:0];
      chk("word0_after_rst", LW'(c0), LW'(exp0));

      step();
      set_req(0, 1'b0, 1'b0, 32'h0, '0, '0);
      step(); idle();
      @(negedge clk); c0 = resp_rdata[31:0];
      repeat (4) step();
      set_req(0, 1'b0, 1'b0, 32'h0, '0, '0);
      step(); idle();
      @(negedge clk); c1 = resp_rdata[31:0];
      chk("word0_delta", LW'(c1 - c0), LW'(expd));

      step();
      rdy = '0;
      for (int c = 0; c < 800; c++) begin
         for (int q = 0; q < NP; q++) begin
            if (!req_valid[q] || rdy[q]) new_rand(q);
         end
         @(negedge clk);
         rdy = req_ready;
         step();
      end
      idle();
      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
